load_data_unit: RTL and testbench

LOAD_DATA_UNIT -- requirements
Module: load_data_unit

---
 rtl/load_pkg.sv | 36 +++
 rtl/load_data_unit_if.sv | 41 ++++
 rtl/load_extract.sv | 33 +++
 rtl/load_data_unit.sv | 158 +++++++++++++++
 tb/tb_load_data_unit.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the load data unit: load-mode codes, FSM states and
// the access-size lookup used by both the control path and the bench.
package load_pkg;

    typedef enum logic [2:0] {
        MODE_NOREGWRITE = 3'd0,
        MODE_LB         = 3'd1,
        MODE_LH         = 3'd2,
        MODE_LW         = 3'd3,
        MODE_LBU        = 3'd4,
        MODE_LHU        = 3'd5,
        MODE_LWU        = 3'd6,
        MODE_LD         = 3'd7
    } load_mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        WAIT0  = 3'd2,
        ISSUE1 = 3'd3,
        WAIT1  = 3'd4,
        RESP   = 3'd5
    } state_e;

    // Bytes touched by a load; NOREGWRITE touches nothing.
    function automatic logic [3:0] access_bytes(input logic [2:0] mode);
        case (mode)
            MODE_LB, MODE_LBU:  access_bytes = 4'd1;
            MODE_LH, MODE_LHU:  access_bytes = 4'd2;
            MODE_LW, MODE_LWU:  access_bytes = 4'd4;
            MODE_LD:            access_bytes = 4'd8;
            default:            access_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_data_unit_if.sv
// Request, memory and writeback handshakes of the load data unit.
// master = requester/memory side, slave = the load data unit itself.
interface load_data_unit_if #(parameter int XLEN = 32);

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic [2:0]      req_mode;
    logic [4:0]      req_rd;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_rd;
    logic            rsp_fault;

    modport master (
        output req_valid, req_addr, req_mode, req_rd,
        input  req_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  rsp_valid, rsp_data, rsp_rd, rsp_fault,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_addr, req_mode, req_rd,
        output req_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output rsp_valid, rsp_data, rsp_rd, rsp_fault,
        input  rsp_ready
    );

endinterface

// File: rtl/load_extract.sv
// Combinational result formatter: aligns {hi,lo} by the byte offset, then
// narrows to the mode width with sign or zero extension.
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              hi,
    input  logic [XLEN-1:0]              lo,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  load_mode_e                   mode,
    output logic [XLEN-1:0]              data
);

    logic [2*XLEN-1:0] shifted;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        shifted = {hi, lo} >> {offset, 3'b000};
        data    = '0;
        case (mode)
            MODE_LB:  data = XLEN'(signed'(shifted[7:0]));
            MODE_LH:  data = XLEN'(signed'(shifted[15:0]));
            MODE_LW:  data = XLEN'(signed'(shifted[31:0]));
            MODE_LBU: data = XLEN'(shifted[7:0]);
            MODE_LHU: data = XLEN'(shifted[15:0]);
            MODE_LWU: data = XLEN'(shifted[31:0]);
            MODE_LD:  data = shifted[XLEN-1:0];
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/load_data_unit.sv
// Load data unit: one outstanding load, one or two word reads, extended result.
// Define MISALIGNED_SPLIT_EN to serve word-crossing loads with two reads.
module load_data_unit
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst_n,
    load_data_unit_if.slave bus
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    load_mode_e      mode_q, mode_d;
    logic [4:0]      rd_q, rd_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] hi_word;
    logic [XLEN-1:0] word_addr;
    logic [XLEN-1:0] ext_data;

    load_mode_e      req_mode_e;
    logic            req_bad_width;
    logic            req_fault;

    assign req_mode_e    = load_mode_e'(bus.req_mode);
    // Doubleword loads do not exist on a 32-bit datapath.
    assign req_bad_width = (XLEN == 32) && (req_mode_e == MODE_LWU || req_mode_e == MODE_LD);
    assign word_addr     = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

`ifdef MISALIGNED_SPLIT_EN
    logic [XLEN-1:0] hi_q, hi_d;
    logic            span;

    assign req_fault = req_bad_width;
    assign span      = (5'(addr_q[OFFW-1:0]) + 5'(access_bytes(mode_q))) > 5'(BYTES);
    assign hi_word   = hi_q;
`else
    logic [4:0] req_off, req_size;

    assign req_off   = 5'(bus.req_addr[OFFW-1:0]);
    assign req_size  = 5'(access_bytes(bus.req_mode));
    assign req_fault = req_bad_width || ((req_mode_e != MODE_NOREGWRITE) &&
                       ((req_off & (req_size - 5'd1)) != 5'd0));
    assign hi_word   = '0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        rd_d    = rd_q;
        fault_d = fault_q;
        lo_d    = lo_q;
`ifdef MISALIGNED_SPLIT_EN
        hi_d    = hi_q;
`endif
        case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d  = bus.req_addr;
                mode_d  = req_mode_e;
                rd_d    = bus.req_rd;
                fault_d = req_fault;
                lo_d    = '0;
`ifdef MISALIGNED_SPLIT_EN
                hi_d    = '0;
`endif
                state_d = (req_fault || req_mode_e == MODE_NOREGWRITE) ? RESP : ISSUE0;
            end
            ISSUE0: if (bus.mem_req_ready) state_d = WAIT0;
            WAIT0: if (bus.mem_rsp_valid) begin
                lo_d = bus.mem_rsp_data;
`ifdef MISALIGNED_SPLIT_EN
                state_d = span ? ISSUE1 : RESP;
`else
                state_d = RESP;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            ISSUE1: if (bus.mem_req_ready) state_d = WAIT1;
            WAIT1: if (bus.mem_rsp_valid) begin
                hi_d    = bus.mem_rsp_data;
                state_d = RESP;
            end
`endif
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mode_q  <= MODE_NOREGWRITE;
            rd_q    <= '0;
            fault_q <= 1'b0;
            lo_q    <= '0;
`ifdef MISALIGNED_SPLIT_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            rd_q    <= rd_d;
            fault_q <= fault_d;
            lo_q    <= lo_d;
`ifdef MISALIGNED_SPLIT_EN
            hi_q    <= hi_d;
`endif
        end
    end

    load_extract #(.XLEN(XLEN)) u_extract (
        .hi     (hi_word),
        .lo     (lo_q),
        .offset (addr_q[OFFW-1:0]),
        .mode   (mode_q),
        .data   (ext_data)
    );

    // Outputs are gated by state so everything but req_ready is zero while idle or in reset.
    always_comb begin
        bus.req_ready     = (state_q == IDLE);
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = '0;
        bus.rsp_valid     = 1'b0;
        bus.rsp_data      = '0;
        bus.rsp_rd        = '0;
        bus.rsp_fault     = 1'b0;
        case (state_q)
            ISSUE0: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = word_addr;
            end
`ifdef MISALIGNED_SPLIT_EN
            ISSUE1: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = word_addr + XLEN'(BYTES);
            end
`endif
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rd    = rd_q;
                bus.rsp_fault = fault_q;
                bus.rsp_data  = (fault_q || mode_q == MODE_NOREGWRITE) ? '0 : ext_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_data_unit.sv
// Scoreboard bench for load_data_unit at XLEN=32: byte-level reference model,
// directed corner cases, mid-operation reset and randomized traffic.
module tb_load_data_unit;
    import load_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_data_unit_if #(.XLEN(XLEN)) bus ();

    load_data_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
        int          accept_cyc;
        int          lat;
        bit          chk_lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_exp_q[$];
    logic [31:0] mem_init [logic [31:0]];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit in_resp        = 0;
    int stall_req      = 0;
    bit rand_ready     = 0;
    bit rand_mem_ready = 0;
    bit noise_en       = 0;
    bit spurious       = 0;
    bit zero_wait      = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: explicit words where a test needs them, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    // Reference: gather bytes little-endian from the byte address, then extend.
    function automatic exp_t model(input logic [31:0] a, input logic [2:0] m, input logic [4:0] rd);
        exp_t        e;
        int          size;
        bit          sgn;
        logic [63:0] val;
        logic [31:0] ai;
        e.rd = rd; e.data = '0; e.fault = 1'b0; e.lat = 1; e.accept_cyc = 0; e.chk_lat = 1'b0;
        sgn = 1'b0;
        case (m)
            3'd1: begin size = 1; sgn = 1'b1; end
            3'd2: begin size = 2; sgn = 1'b1; end
            3'd3: begin size = 4; sgn = 1'b1; end
            3'd4: size = 1;
            3'd5: size = 2;
            3'd6: size = 4;
            3'd7: size = 8;
            default: size = 0;
        endcase
        if (size == 0) return e;
        if (m == 3'd6 || m == 3'd7) begin e.fault = 1'b1; return e; end
`ifndef MISALIGNED_SPLIT_EN
        if ((a % size) != 0) begin e.fault = 1'b1; return e; end
`endif
        val = '0;
        for (int i = 0; i < size; i++) begin
            ai  = a + 32'(i);
            val = val | (64'(mem_byte(ai)) << (8 * i));
        end
        if (sgn && val[8*size-1]) val = val | (~64'd0 << (8 * size));
        e.data = val[31:0];
        e.lat  = ((a % 4) + size > 4) ? 5 : 3;
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [2:0] m, input logic [4:0] rd,
                        input bit expect_rsp, output int acc);
        exp_t e;
        int   waited;
        bit   ok;
        waited = 0; ok = 0; acc = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_mode = m; bus.req_rd = rd;
        while (!ok && waited < 300) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1; else waited++;
        end
        if (!ok) check(1'b0, "req_accept_timeout", 64'(waited), 64'd0);
        else begin
            e = model(a, m, rd);
            e.accept_cyc = cyc;
            e.chk_lat    = zero_wait;
            acc          = cyc;
            if (expect_rsp) exp_q.push_back(e);
            if (e.lat >= 3) mem_exp_q.push_back({a[31:2], 2'b00});
            if (e.lat == 5) mem_exp_q.push_back({a[31:2], 2'b00} + 32'd4);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_resp) && n < 1000) begin @(posedge clk); n++; end
        if (n >= 1000) check(1'b0, "drain_timeout", 64'(n), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(bus.req_ready == 1'b1,     {tag, "_req_ready"},     64'(bus.req_ready), 64'd1);
        check(bus.rsp_valid == 1'b0,     {tag, "_rsp_valid"},     64'(bus.rsp_valid), 64'd0);
        check(bus.rsp_data == '0,        {tag, "_rsp_data"},      64'(bus.rsp_data), 64'd0);
        check(bus.rsp_rd == '0,          {tag, "_rsp_rd"},        64'(bus.rsp_rd), 64'd0);
        check(bus.rsp_fault == 1'b0,     {tag, "_rsp_fault"},     64'(bus.rsp_fault), 64'd0);
        check(bus.mem_req_valid == 1'b0, {tag, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        check(bus.mem_req_addr == '0,    {tag, "_mem_req_addr"},  64'(bus.mem_req_addr), 64'd0);
    endtask

    // Memory: zero-wait responder, checks every read command against the scoreboard.
    initial begin
        bit          hs;
        logic [31:0] ha;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs = bus.mem_req_valid && bus.mem_req_ready && rst_n;
            ha = bus.mem_req_addr;
            if (hs) begin
                if (mem_exp_q.size() == 0) check(1'b0, "unexpected_mem_req", 64'(ha), 64'd0);
                else begin
                    logic [31:0] ea;
                    ea = mem_exp_q.pop_front();
                    check(ha == ea, "mem_req_addr", 64'(ha), 64'(ea));
                end
            end
            @(posedge clk); #1;
            bus.mem_rsp_valid = hs || spurious || (noise_en && $urandom_range(0, 7) == 0);
            bus.mem_rsp_data  = hs ? mem_word(ha) : $urandom();
            bus.mem_req_ready = rand_mem_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Response monitor: drives rsp_ready, pops the scoreboard, checks hold-stability.
    initial begin
        exp_t        cur;
        bit          have;
        bit          ready;
        int          stall_left;
        logic [31:0] held_data;
        logic [4:0]  held_rd;
        have = 0; stall_left = 0; held_data = '0; held_rd = '0;
        cur.data = '0; cur.rd = '0; cur.fault = 1'b0; cur.accept_cyc = 0; cur.lat = 0; cur.chk_lat = 1'b0;
        bus.rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_resp = 0;
                bus.rsp_ready = 1'b1;
            end else if (bus.rsp_valid) begin
                if (!in_resp) begin
                    in_resp    = 1;
                    held_data  = bus.rsp_data;
                    held_rd    = bus.rsp_rd;
                    stall_left = stall_req;
                    stall_req  = 0;
                    if (exp_q.size() == 0) begin
                        have = 0;
                        check(1'b0, "unexpected_rsp", 64'(bus.rsp_data), 64'd0);
                    end else begin
                        have = 1;
                        cur  = exp_q.pop_front();
                        if (cur.chk_lat)
                            check(cyc - cur.accept_cyc == cur.lat, "latency",
                                  64'(cyc - cur.accept_cyc), 64'(cur.lat));
                    end
                end else begin
                    check(bus.rsp_data == held_data, "rsp_data_stable", 64'(bus.rsp_data), 64'(held_data));
                    check(bus.rsp_rd == held_rd, "rsp_rd_stable", 64'(bus.rsp_rd), 64'(held_rd));
                end
                check(bus.req_ready == 1'b0, "req_ready_in_resp", 64'(bus.req_ready), 64'd0);
                if (stall_left > 0) begin
                    ready = 1'b0;
                    stall_left--;
                end else begin
                    ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                bus.rsp_ready = ready;
                if (ready) begin
                    if (have) begin
                        check(bus.rsp_data == cur.data, "rsp_data", 64'(bus.rsp_data), 64'(cur.data));
                        check(bus.rsp_rd == cur.rd, "rsp_rd", 64'(bus.rsp_rd), 64'(cur.rd));
                        check(bus.rsp_fault == cur.fault, "rsp_fault", 64'(bus.rsp_fault), 64'(cur.fault));
                    end
                    in_resp = 0;
                end
            end else begin
                bus.rsp_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc;
        logic [31:0] a;
        logic [31:0] ra;
        int          rdelay;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_mode = '0; bus.req_rd = '0;
        rst_n = 1'b1;
        mem_init[32'h0000_0100] = 32'h8012_3456;
        mem_init[32'h0000_0200] = 32'hAB00_0000;
        mem_init[32'h0000_0204] = 32'h0000_00CD;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2 rst_n = 1'b1;

        // Directed corner cases with zero-wait memory and immediate writeback.
        send(32'h0000_0103, MODE_LB,         5'd5, 1, acc);
        send(32'h0000_0203, MODE_LHU,        5'd6, 1, acc);
        send(32'hFFFF_FFFE, MODE_LW,         5'd7, 1, acc);
        send(32'h0000_0100, MODE_LD,         5'd8, 1, acc);
        send(32'h0000_0105, MODE_NOREGWRITE, 5'd9, 1, acc);
        send(32'h0000_0100, MODE_LBU,        5'd1, 1, acc);
        wait_idle();

        // Writeback stalled for five cycles while the response is held.
        stall_req = 5;
        send(32'h0000_0100, MODE_LW, 5'd10, 1, acc);
        wait_idle();

        // Reset while a memory read is in flight; its late data must be ignored.
`ifdef MISALIGNED_SPLIT_EN
        ra = 32'h0000_0302; rdelay = 4;
`else
        ra = 32'h0000_0300; rdelay = 2;
`endif
        send(ra, MODE_LW, 5'd12, 0, acc);
        while (cyc < acc + rdelay) begin @(posedge clk); #1; end
        #2;
        rst_n    = 1'b0;
        spurious = 1'b1;
        check(mem_exp_q.size() == 0, "mem_reqs_before_reset", 64'(mem_exp_q.size()), 64'd0);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check(bus.rsp_valid == 1'b0 && bus.mem_req_valid == 1'b0 && bus.req_ready == 1'b1,
                  "idle_after_reset", {61'd0, bus.rsp_valid, bus.mem_req_valid, bus.req_ready}, 64'd1);
        end
        spurious = 1'b0;
        send(32'h0000_0100, MODE_LW, 5'd11, 1, acc);
        wait_idle();

        // Random traffic with zero-wait memory: latency still checked.
        noise_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       a = $urandom();
                1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: a = 32'h0000_0200 + 32'($urandom_range(0, 15));
            endcase
            send(a, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1, acc);
        end
        wait_idle();

        // Random traffic with memory and writeback back-pressure.
        zero_wait      = 1'b0;
        rand_mem_ready = 1'b1;
        rand_ready     = 1'b1;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 2))
                0:       a = $urandom();
                1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: a = 32'h0000_0100 + 32'($urandom_range(0, 15));
            endcase
            send(a, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1, acc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle();

        check(exp_q.size() == 0, "rsp_queue_empty", 64'(exp_q.size()), 64'd0);
        check(mem_exp_q.size() == 0, "mem_queue_empty", 64'(mem_exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
